// File: rtl/csr_pkg.sv
// Shared CSR addresses, trap cause codes and field encodings for the
// machine-mode CSR file and trap controller.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [4:0] EXC_ILLEGAL = 5'd2;
  localparam logic [4:0] EXC_BREAK   = 5'd3;
  localparam logic [4:0] EXC_ECALL   = 5'd11;
  localparam logic [4:0] IRQ_MSI     = 5'd3;
  localparam logic [4:0] IRQ_MTI     = 5'd7;
  localparam logic [4:0] IRQ_MEI     = 5'd11;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_e;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent half writes; a write to
// either half suppresses the increment (and any carry) for that cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata_lo,
  input  logic [31:0] wdata_hi,
  output logic [63:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wdata_lo;
      if (wr_hi) count[63:32] <= wdata_hi;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the single-cycle core:
// prioritised exceptions, masked interrupts, direct/vectored mtvec, mret.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter bit              HAS_COUNTERS = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter logic [XLEN-1:0] HARTID       = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            retire_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      csr_op_i,
  input  logic            csr_nowrite_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  input  logic            ecall_i,
  input  logic            ebreak_i,
  input  logic            mret_i,
  input  logic            illegal_i,
  input  logic [XLEN-1:0] tval_i,
  input  logic            irq_ext_i,
  input  logic            irq_soft_i,
  input  logic            irq_timer_i,
  output logic            trap_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            mie_o
);

  localparam logic [XLEN-1:0] IRQ_MASK       = XLEN'(12'h888);
  localparam mtvec_mode_e     MTVEC_MODE_RST = MTVEC_RESET[1] ? MTVEC_DIRECT
                                             : mtvec_mode_e'(MTVEC_RESET[1:0]);

  logic            mstatus_mie_q, mstatus_mpie_q;
  logic [XLEN-1:0] mie_q, mip_q, mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [XLEN-3:0] mtvec_base_q;
  mtvec_mode_e     mtvec_mode_q;
  logic [63:0]     mcycle, minstret;

  logic [XLEN-1:0] mstatus_rd, csr_old, wval, trap_tval, trap_base, trap_target;
  logic [63:0]     wval64;
  logic [31:0]     wdata_hi;
  logic            csr_impl, csr_wr_req, csr_ill;
  logic [XLEN-1:0] irq_pend;
  logic            irq_take, trap_take, trap_irq, commit, csr_we, mret_take;
  logic [4:0]      irq_code, trap_code;
  logic            cyc_wr_lo, cyc_wr_hi, ret_wr_lo, ret_wr_hi;

  always_comb begin
    mstatus_rd        = '0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[7]     = mstatus_mpie_q;
    mstatus_rd[3]     = mstatus_mie_q;
  end

  // Read mux doubles as the implemented-address decoder.
  always_comb begin
    csr_old  = '0;
    csr_impl = 1'b1;
    case (csr_addr_i)
      CSR_MSTATUS:   csr_old = mstatus_rd;
      CSR_MIE:       csr_old = mie_q;
      CSR_MTVEC:     csr_old = {mtvec_base_q, mtvec_mode_q};
      CSR_MSCRATCH:  csr_old = mscratch_q;
      CSR_MEPC:      csr_old = mepc_q;
      CSR_MCAUSE:    csr_old = mcause_q;
      CSR_MTVAL:     csr_old = mtval_q;
      CSR_MIP:       csr_old = mip_q;
      CSR_MCYCLE:    begin csr_old = XLEN'(mcycle);          csr_impl = HAS_COUNTERS; end
      CSR_MINSTRET:  begin csr_old = XLEN'(minstret);        csr_impl = HAS_COUNTERS; end
      CSR_MCYCLEH:   begin csr_old = XLEN'(mcycle[63:32]);   csr_impl = HAS_COUNTERS && (XLEN == 32); end
      CSR_MINSTRETH: begin csr_old = XLEN'(minstret[63:32]); csr_impl = HAS_COUNTERS && (XLEN == 32); end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_old = '0;
      CSR_MHARTID:   csr_old = HARTID;
      default:       csr_impl = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      CSR_RW:  wval = csr_wdata_i;
      CSR_RS:  wval = csr_old | csr_wdata_i;
      CSR_RC:  wval = csr_old & ~csr_wdata_i;
      default: wval = csr_old;
    endcase
  end

  assign csr_wr_req = (csr_op_i == CSR_RW) ||
                      (((csr_op_i == CSR_RS) || (csr_op_i == CSR_RC)) && !csr_nowrite_i);
  assign csr_ill    = ((csr_op_i != CSR_NONE) && !csr_impl) ||
                      ((csr_addr_i[11:4] == 8'hF1) && csr_wr_req);

  assign irq_pend = mip_q & mie_q;
  assign irq_take = mstatus_mie_q && (irq_pend != '0);
  assign irq_code = irq_pend[11] ? IRQ_MEI : (irq_pend[3] ? IRQ_MSI : IRQ_MTI);

  always_comb begin
    trap_take = 1'b0;
    trap_irq  = 1'b0;
    trap_code = '0;
    trap_tval = '0;
    if (retire_i) begin
      if (irq_take) begin
        trap_take = 1'b1;
        trap_irq  = 1'b1;
        trap_code = irq_code;
      end else if (illegal_i || csr_ill) begin
        trap_take = 1'b1;
        trap_code = EXC_ILLEGAL;
        trap_tval = tval_i;
      end else if (ebreak_i) begin
        trap_take = 1'b1;
        trap_code = EXC_BREAK;
        trap_tval = pc_i;
      end else if (ecall_i) begin
        trap_take = 1'b1;
        trap_code = EXC_ECALL;
      end
    end
  end

  assign commit    = retire_i && !trap_take;
  assign csr_we    = commit && csr_wr_req;
  assign mret_take = commit && mret_i;

  assign trap_base   = {mtvec_base_q, 2'b00};
  assign trap_target = ((mtvec_mode_q == MTVEC_VECTORED) && trap_irq)
                     ? trap_base + (XLEN'(trap_code) << 2) : trap_base;

  assign trap_o        = trap_take && !reset;
  assign redirect_o    = (trap_take || mret_take) && !reset;
  assign redirect_pc_o = trap_take ? trap_target : mepc_q;
  assign csr_rdata_o   = reset ? '0 : csr_old;
  assign mie_o         = mstatus_mie_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mscratch_q     <= '0;
      mtvec_base_q   <= MTVEC_RESET[XLEN-1:2];
      mtvec_mode_q   <= MTVEC_MODE_RST;
    end else begin
      mip_q <= XLEN'({irq_ext_i, 3'b000, irq_timer_i, 3'b000, irq_soft_i, 3'b000});
      if (trap_take) begin
        mepc_q         <= pc_i & ~XLEN'(3);
        mcause_q       <= {trap_irq, (XLEN-1)'(trap_code)};
        mtval_q        <= trap_tval;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else begin
        if (mret_take) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end else if (csr_we && (csr_addr_i == CSR_MSTATUS)) begin
          mstatus_mie_q  <= wval[3];
          mstatus_mpie_q <= wval[7];
        end
        if (csr_we) begin
          case (csr_addr_i)
            CSR_MIE:      mie_q      <= wval & IRQ_MASK;
            CSR_MTVEC: begin
              mtvec_base_q <= wval[XLEN-1:2];
              // Reserved modes (1x) leave the current mode in place.
              if (!wval[1]) mtvec_mode_q <= mtvec_mode_e'(wval[1:0]);
            end
            CSR_MSCRATCH: mscratch_q <= wval;
            CSR_MEPC:     mepc_q     <= wval & ~XLEN'(3);
            CSR_MCAUSE:   mcause_q   <= wval;
            CSR_MTVAL:    mtval_q    <= wval;
            default: ;
          endcase
        end
      end
    end
  end

  // At XLEN=64 the low-half address carries the full 64-bit value.
  assign wval64    = 64'(wval);
  assign wdata_hi  = (XLEN == 64) ? wval64[63:32] : wval64[31:0];
  assign cyc_wr_lo = csr_we && (csr_addr_i == CSR_MCYCLE);
  assign cyc_wr_hi = csr_we && ((XLEN == 64) ? (csr_addr_i == CSR_MCYCLE) : (csr_addr_i == CSR_MCYCLEH));
  assign ret_wr_lo = csr_we && (csr_addr_i == CSR_MINSTRET);
  assign ret_wr_hi = csr_we && ((XLEN == 64) ? (csr_addr_i == CSR_MINSTRET) : (csr_addr_i == CSR_MINSTRETH));

  if (HAS_COUNTERS) begin : g_counters
    csr_counter64 u_mcycle (
      .clk      (clock),
      .rst      (reset),
      .inc      (1'b1),
      .wr_lo    (cyc_wr_lo),
      .wr_hi    (cyc_wr_hi),
      .wdata_lo (wval64[31:0]),
      .wdata_hi (wdata_hi),
      .count    (mcycle)
    );
    csr_counter64 u_minstret (
      .clk      (clock),
      .rst      (reset),
      .inc      (commit),
      .wr_lo    (ret_wr_lo),
      .wr_hi    (ret_wr_hi),
      .wdata_lo (wval64[31:0]),
      .wdata_hi (wdata_hi),
      .count    (minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap controller for the single-cycle RV core.
- Replaces the fixed CSR behaviour: hardwired mcause=11, mepc-only save and direct mtvec.
- Adds:
  - prioritised synchronous exceptions;
  - three interrupt sources with mie/mip masking;
  - direct and vectored mtvec;
  - mret stack handling (MIE/MPIE);
  - 64-bit mcycle/minstret counters.
- The core applies redirect_pc_o as nextPC whenever redirect_o=1, and suppresses register and memory writes when trap_o=1.

Parameters:
- XLEN, 32, datapath width; only 32 or 64 allowed. At 64, the *h counter CSRs are unimplemented.
- HAS_COUNTERS, 1, 0 removes mcycle/minstret; their addresses become illegal.
- MTVEC_RESET, 0, reset value of mtvec.
- HARTID, 0, value read from mhartid.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- retire_i  in  1  an instruction completes this cycle; gates all commits
- pc_i  in  XLEN  PC of the retiring instruction
- csr_op_i  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_nowrite_i  in  1  rs1=x0 or uimm=0; suppresses the write for RS/RC
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  rs1 or zero-extended uimm
- csr_rdata_o  out  XLEN  combinational old value at csr_addr_i
- ecall_i, ebreak_i, mret_i, illegal_i  in  1 each  decoded instruction class
- tval_i  in  XLEN  instruction bits for illegal-instruction traps
- irq_ext_i, irq_soft_i, irq_timer_i  in  1 each  level-sensitive interrupt requests
- trap_o  out  1  trap taken this cycle
- redirect_o  out  1  trap_o or mret commit
- redirect_pc_o  out  XLEN  target PC when redirect_o=1
- mie_o  out  1  mstatus.MIE

Behaviour:
- Reset values (all zero unless stated):
  - mstatus.MIE and mstatus.MPIE are 0.
  - mstatus.MPP is hardwired 2'b11.
  - mie, mepc, mcause, mtval, mscratch, counters and mip_q are 0.
  - mtvec is MTVEC_RESET.
  - trap_o, redirect_o and csr_rdata_o are forced to 0 while reset is high.
- mip_q:
  - One register stage samples {irq_ext_i→bit11, irq_timer_i→bit7, irq_soft_i→bit3} every cycle.
  - CSR writes to mip are ignored; reads return mip_q.
- Implemented CSRs:
  - mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344.
  - mcycle B00, minstret B02, mcycleh B80, minstreth B82.
  - mvendorid F11, marchid F12, mimpid F13 (all read 0).
  - mhartid F14.
- CSR illegal condition (csr_ill): any of
  - csr_op_i≠00 and the address is unimplemented;
  - a write to an F1x address, unless csr_nowrite_i=1 with an RS/RC op.
- Trap priority, evaluated only when retire_i=1 (first match wins):
  1. Interrupt: MIE=1 and (mip_q & mie)≠0. Among pending interrupts, priority is MEI(11) > MSI(3) > MTI(7).
  2. Illegal: illegal_i or csr_ill gives cause 2, mtval=tval_i.
  3. Ebreak: cause 3, mtval=pc_i.
  4. Ecall: cause 11, mtval=0.
- On trap, at the clock edge:
  - mepc ← {pc_i[XLEN-1:2],2'b00}; mcause ← {interrupt bit at MSB, code}.
  - MPIE ← MIE; MIE ← 0.
  - The instruction's CSR write, mret and minstret increment are all discarded.
- Trap target:
  - mtvec.MODE=00, or any synchronous trap: target is {BASE,2'b00}.
  - MODE=01 and interrupt: target is {BASE,2'b00}+4·code.
  - Writes setting MODE to 1x keep the old MODE but still update BASE.
- mret, when retire_i and no trap:
  - redirect_pc_o=mepc.
  - MIE ← MPIE; MPIE ← 1.
  - redirect_o=1 and trap_o=0.
- CSR write, when retire_i, op≠00, no trap:
  - RW writes csr_wdata_i; RS writes old|wdata; RC writes old&~wdata.
  - RS/RC perform no write when csr_nowrite_i=1.
  - mepc bits[1:0] always read 0.
  - Only MIE/MPIE are writable in mstatus.
  - Only bits 11, 7 and 3 are writable in mie.
- Counters:
  - mcycle increments every cycle after reset.
  - minstret increments on a retire with no trap, including mret and CSR instructions.
  - A CSR write to either half wins over the increment for that cycle. The other half holds, with no carry that cycle.
  - Counters wrap at 2^64−1 to 0.
- Simultaneous events:
  - An interrupt in the same cycle as a CSR write to mstatus/mie uses the pre-write values.
  - An interrupt in the same cycle as mret takes the trap; mepc=pc_i, so the mret re-executes after the handler.
  - Interrupts pending while retire_i=0 wait; there is no loss because the sources are level-sensitive.

Decomposition:
- Package csr_pkg holds:
  - CSR address constants;
  - cause codes (2, 3, 11; IRQ 3, 7, 11);
  - csr_op encoding;
  - the mtvec mode enum.
- One sub-module, csr_counter64: a 64-bit counter with inc, wr_lo and wr_hi enables and the wrap rule above; instantiated twice.

Test Plan:
- Trap/return round trip:
  - Reset, then ecall at pc_i=0x80000010 with mtvec=0x80001000 → trap_o=1, redirect_pc_o=0x80001000, mcause=0xB, mepc=0x80000010, mtval=0.
  - Then mret → redirect_pc_o=0x80000010, MIE=old MPIE, MPIE=1.
- Vectored timer interrupt:
  - Setup: mtvec=0x80000101, mie=0x80, MIE=1.
  - Stimulus: assert irq_timer_i; the next retire, one cycle after mip_q sets, has pc_i=0x80000200.
  - Expected: trap_o=1, redirect_pc_o=0x8000011C, mcause=0x80000007, mepc=0x80000200, MIE=0, MPIE=1.
- Interrupt priority: all three IRQs and all mie bits set → mcause=0x8000000B. With MIE=0 → no trap.
- Illegal CSR accesses:
  - CSRRW to 0xF14 → cause 2, mtval=tval_i, mhartid unchanged.
  - CSRRS with csr_nowrite_i=1 to 0xF14 → rdata=HARTID, no trap.
  - CSRRW to 0x7C0 → cause 2.
- Set/clear semantics: CSRRS mie 0x888 then CSRRC 0x008 → mie reads 0x880. Write mtvec 0x3 → MODE stays at its old value.
- Counters:
  - Write mcycle=0xFFFFFFFF → the next cycle reads mcycle=0, mcycleh=1.
  - Write mcycleh=5 while lower is 0xFFFFFFFF → mcycleh=5, no carry that cycle.
  - Trapped retire → minstret unchanged.
  - Reset asserted mid-count → all counters 0 next cycle.
